alu_exec_stage: RTL and testbench
=================================

Name: alu_exec_stage

Overview:
- Execute/writeback stage wrapped around the existing combinational ALU (N-bit, 3-bit op, carry_in → c, carry_out, a_gt_b, a_eq_b, c_eq_zero).
- Accepts instructions over a valid/ready handshake and reads operands from an internal register file.
- Drives the ALU from an issue register, then writes the result and a 4-bit flag register back, with bypass for back-to-back dependencies.
- Sits between the instruction sequencer (upstream) and the ALU instance (peer, instantiated by the parent).

Parameters:
N, 8, datapath width
REGS, 8, register file depth (power of 2, ≥2)
AW, $clog2(REGS), register address width (derived; not overridden)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  instruction offered
in_ready  output  1  stage can accept; = !ld_valid
in_op  input  3  ALU opcode (000 add, 001 shr, 010 shl, 011 not, 100 and, 101 or, 110 xor, 111 cmp)
in_ra  input  AW  source A register
in_rb  input  AW  source B register
in_rd  input  AW  destination register
in_wr_en  input  1  write result to rd
in_use_carry  input  1  feed carry flag into ALU carry_in
ld_valid  input  1  direct register load (priority over issue)
ld_addr  input  AW  load address
ld_data  input  N  load data
alu_a  output  N  to ALU a
alu_b  output  N  to ALU b
alu_op  output  3  to ALU op
alu_carry_in  output  1  to ALU carry_in
alu_c  input  N  from ALU c
alu_carry_out  input  1  from ALU
alu_a_gt_b  input  1  from ALU
alu_a_eq_b  input  1  from ALU
alu_c_eq_zero  input  1  from ALU
retire_valid  output  1  instruction completing this cycle
retire_data  output  N  result of retiring instruction
flag_carry, flag_gt, flag_eq, flag_zero  output  1 each  flag register
dbg_addr  input  AW  debug read address
dbg_data  output  N  combinational read of regfile[dbg_addr]

Behaviour:
- Reset (async, immediate): all regfile entries 0, all flags 0, ex_valid 0, alu_* 0, retire_valid 0, retire_data 0. Any in-flight instruction is discarded with no writeback or flag update.
- Accept: at a rising edge where in_valid && in_ready. The issue register captures op, rd, wr_en, operand A, operand B and carry C (C = in_use_carry ? carry source : 0). ex_valid ← 1; otherwise ex_valid ← 0.
- Execute cycle (ex_valid=1): alu_a/alu_b/alu_op/alu_carry_in driven from the issue register. retire_valid=1 and retire_data=alu_c, both combinational from the ALU.
- While ex_valid=0, alu_* are driven 0.
- Writeback at the edge ending the execute cycle:
  - if ex_wr_en, regfile[ex_rd] ← alu_c;
  - always flag_carry←alu_carry_out, flag_gt←alu_a_gt_b, flag_eq←alu_a_eq_b, flag_zero←alu_c_eq_zero.
- Latency: accept at edge E0 → ALU driven during cycle E0..E1 → register and flags visible after E1. Throughput is one instruction per cycle; no stalls from dependencies.
- Bypass at accept, when ex_valid=1:
  - if ex_wr_en and in_ra==ex_rd, A ← alu_c; the same rule applies to in_rb/B;
  - carry source = alu_carry_out; otherwise carry source = flag_carry.
- Load port:
  - ld_valid forces in_ready=0.
  - regfile[ld_addr] ← ld_data at the edge.
  - If a writeback targets the same address at the same edge, the load wins (it is later in program order).
  - A load does not change flags.
- Op 111 with wr_en=0 is the normal compare usage. wr_en=1 with op 111 is legal and writes alu_c.
- Width: all arithmetic is done by the ALU. This stage performs no arithmetic and applies no truncation.
- dbg_data reflects writes after the edge (no read-during-write bypass).

Test Plan:
- Load r1=4, r2=8; issue add rd=r3, use_carry=0 → during execute alu_a=4, alu_b=8, alu_op=000, alu_carry_in=0, retire_data=12; then dbg r3=12, flags carry=0 gt=0 eq=0 zero=0.
- Carry bypass: load r6=255, r7=1; issue add r3=r6+r7, then next cycle add use_carry r5=r1(4)+r2(8) → first retires 0 with carry=1, zero=1; second sees alu_carry_in=1, r5=13, flag_carry=0.
- Data bypass: add r3=r1+r2 (12), immediately xor r4=r3^r2 → second execute alu_a=12 (not stale 0), r4=4.
- Compare: load r1=8, r2=4; cmp wr_en=0 → gt=1 eq=0 zero=1, all registers unchanged; then cmp r1,r1 → eq=1 gt=0.
- Load priority: hold in_valid with ld_valid=1 for 3 cycles → in_ready=0, no acceptance; instruction accepted on the first edge after ld_valid drops. Load to r3 coinciding with writeback to r3 → r3=ld_data.
- Reset during execute (ex_valid=1, add pending to r3) → retire_valid drops immediately; r3 and flags read 0; in_ready=1 after reset release.

Source files
------------

// File: rtl/alu_exec_stage_if.sv
// Bundle between the instruction sequencer, the execute stage and the peer ALU.
// The stage uses the slave view; the sequencer/ALU side uses the master view.
interface alu_exec_stage_if #(
  parameter int N    = 8,
  parameter int REGS = 8
);
  localparam int AW = $clog2(REGS);

  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [AW-1:0] in_ra;
  logic [AW-1:0] in_rb;
  logic [AW-1:0] in_rd;
  logic          in_wr_en;
  logic          in_use_carry;

  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [N-1:0]  ld_data;

  logic [N-1:0]  alu_a;
  logic [N-1:0]  alu_b;
  logic [2:0]    alu_op;
  logic          alu_carry_in;
  logic [N-1:0]  alu_c;
  logic          alu_carry_out;
  logic          alu_a_gt_b;
  logic          alu_a_eq_b;
  logic          alu_c_eq_zero;

  logic          retire_valid;
  logic [N-1:0]  retire_data;
  logic          flag_carry;
  logic          flag_gt;
  logic          flag_eq;
  logic          flag_zero;

  logic [AW-1:0] dbg_addr;
  logic [N-1:0]  dbg_data;

  modport slave (
    input  in_valid, in_op, in_ra, in_rb, in_rd, in_wr_en, in_use_carry,
    output in_ready,
    input  ld_valid, ld_addr, ld_data,
    output alu_a, alu_b, alu_op, alu_carry_in,
    input  alu_c, alu_carry_out, alu_a_gt_b, alu_a_eq_b, alu_c_eq_zero,
    output retire_valid, retire_data,
    output flag_carry, flag_gt, flag_eq, flag_zero,
    input  dbg_addr,
    output dbg_data
  );

  modport master (
    output in_valid, in_op, in_ra, in_rb, in_rd, in_wr_en, in_use_carry,
    input  in_ready,
    output ld_valid, ld_addr, ld_data,
    input  alu_a, alu_b, alu_op, alu_carry_in,
    output alu_c, alu_carry_out, alu_a_gt_b, alu_a_eq_b, alu_c_eq_zero,
    input  retire_valid, retire_data,
    input  flag_carry, flag_gt, flag_eq, flag_zero,
    output dbg_addr,
    input  dbg_data
  );
endinterface

// File: rtl/alu_exec_stage.sv
// Execute/writeback stage around an external combinational ALU: accept -> one execute cycle -> regfile/flags at the next edge.
// in_ready = !ld_valid (loads take priority); dependent instructions issue back-to-back through the ALU-result bypass.
module alu_exec_stage #(
  parameter int  N    = 8,
  parameter int  REGS = 8,
  localparam int AW   = $clog2(REGS)
) (
  input logic             clk,
  input logic             reset,
  alu_exec_stage_if.slave bus
);

  logic [N-1:0]  regs_q [REGS];

  logic          ex_valid_q, ex_valid_d;
  logic [2:0]    ex_op_q, ex_op_d;
  logic [AW-1:0] ex_rd_q, ex_rd_d;
  logic          ex_wr_en_q, ex_wr_en_d;
  logic [N-1:0]  ex_a_q, ex_a_d;
  logic [N-1:0]  ex_b_q, ex_b_d;
  logic          ex_c_q, ex_c_d;

  logic          flag_carry_q, flag_gt_q, flag_eq_q, flag_zero_q;

  logic          accept;
  logic          byp_a, byp_b;
  logic          carry_src;
  logic          wb_en;

  assign bus.in_ready = !bus.ld_valid;
  assign accept       = bus.in_valid && bus.in_ready;
  assign wb_en        = ex_valid_q && ex_wr_en_q;

  // The instruction in execute has not written back yet, so its result comes from the ALU.
  assign byp_a     = wb_en && (bus.in_ra == ex_rd_q);
  assign byp_b     = wb_en && (bus.in_rb == ex_rd_q);
  assign carry_src = ex_valid_q ? bus.alu_carry_out : flag_carry_q;

  always_comb begin
    ex_valid_d = accept;
    ex_op_d    = ex_op_q;
    ex_rd_d    = ex_rd_q;
    ex_wr_en_d = ex_wr_en_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    ex_c_d     = ex_c_q;
    if (accept) begin
      ex_op_d    = bus.in_op;
      ex_rd_d    = bus.in_rd;
      ex_wr_en_d = bus.in_wr_en;
      ex_a_d     = byp_a ? bus.alu_c : regs_q[bus.in_ra];
      ex_b_d     = byp_b ? bus.alu_c : regs_q[bus.in_rb];
      ex_c_d     = bus.in_use_carry ? carry_src : 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q <= 1'b0;
      ex_op_q    <= '0;
      ex_rd_q    <= '0;
      ex_wr_en_q <= 1'b0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_c_q     <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_op_q    <= ex_op_d;
      ex_rd_q    <= ex_rd_d;
      ex_wr_en_q <= ex_wr_en_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      ex_c_q     <= ex_c_d;
    end
  end

  // A load at the same edge as a writeback to the same entry is younger and wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < REGS; i++) begin
        if (bus.ld_valid && (bus.ld_addr == AW'(i))) regs_q[i] <= bus.ld_data;
        else if (wb_en && (ex_rd_q == AW'(i)))       regs_q[i] <= bus.alu_c;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_carry_q <= 1'b0;
      flag_gt_q    <= 1'b0;
      flag_eq_q    <= 1'b0;
      flag_zero_q  <= 1'b0;
    end else if (ex_valid_q) begin
      flag_carry_q <= bus.alu_carry_out;
      flag_gt_q    <= bus.alu_a_gt_b;
      flag_eq_q    <= bus.alu_a_eq_b;
      flag_zero_q  <= bus.alu_c_eq_zero;
    end
  end

  assign bus.alu_a        = ex_valid_q ? ex_a_q  : '0;
  assign bus.alu_b        = ex_valid_q ? ex_b_q  : '0;
  assign bus.alu_op       = ex_valid_q ? ex_op_q : 3'b000;
  assign bus.alu_carry_in = ex_valid_q && ex_c_q;

  assign bus.retire_valid = ex_valid_q;
  assign bus.retire_data  = ex_valid_q ? bus.alu_c : '0;

  assign bus.flag_carry = flag_carry_q;
  assign bus.flag_gt    = flag_gt_q;
  assign bus.flag_eq    = flag_eq_q;
  assign bus.flag_zero  = flag_zero_q;

  assign bus.dbg_data = regs_q[bus.dbg_addr];

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage with a behavioural model of the peer ALU.
module tb_alu_exec_stage;
  localparam int N    = 8;
  localparam int REGS = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SHR = 3'b001;
  localparam logic [2:0] OP_SHL = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [N:0] sum;

  alu_exec_stage_if #(.N(N), .REGS(REGS)) bus ();

  alu_exec_stage #(.N(N), .REGS(REGS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Peer ALU: compare produces c=0; carry_out is meaningful only for add.
  always_comb begin
    sum               = '0;
    bus.alu_c         = '0;
    bus.alu_carry_out = 1'b0;
    case (bus.alu_op)
      OP_ADD: begin
        sum               = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {{N{1'b0}}, bus.alu_carry_in};
        bus.alu_c         = sum[N-1:0];
        bus.alu_carry_out = sum[N];
      end
      OP_SHR:  bus.alu_c = bus.alu_a >> 1;
      OP_SHL:  bus.alu_c = bus.alu_a << 1;
      OP_NOT:  bus.alu_c = ~bus.alu_a;
      OP_AND:  bus.alu_c = bus.alu_a & bus.alu_b;
      OP_OR:   bus.alu_c = bus.alu_a | bus.alu_b;
      OP_XOR:  bus.alu_c = bus.alu_a ^ bus.alu_b;
      default: bus.alu_c = '0;
    endcase
    bus.alu_a_gt_b    = bus.alu_a > bus.alu_b;
    bus.alu_a_eq_b    = bus.alu_a == bus.alu_b;
    bus.alu_c_eq_zero = bus.alu_c == '0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input string tag, input logic [2:0] addr, input logic [31:0] exp);
    bus.dbg_addr = addr;
    #1;
    chk(tag, bus.dbg_data, exp);
  endtask

  task automatic set_ins(input logic [2:0] op, input logic [2:0] ra, input logic [2:0] rb,
                         input logic [2:0] rd, input logic wr, input logic uc);
    bus.in_valid     = 1'b1;
    bus.in_op        = op;
    bus.in_ra        = ra;
    bus.in_rb        = rb;
    bus.in_rd        = rd;
    bus.in_wr_en     = wr;
    bus.in_use_carry = uc;
  endtask

  task automatic load(input logic [2:0] addr, input logic [7:0] data);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = addr;
    bus.ld_data  = data;
    tick();
    bus.ld_valid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_ra = '0; bus.in_rb = '0; bus.in_rd = '0;
    bus.in_wr_en = 1'b0; bus.in_use_carry = 1'b0;
    bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    bus.dbg_addr = '0;

    #2;
    chk("rst_retire_valid", bus.retire_valid, 0);
    chk("rst_retire_data", bus.retire_data, 0);
    chk("rst_alu_a", bus.alu_a, 0);
    chk("rst_flags", {bus.flag_carry, bus.flag_gt, bus.flag_eq, bus.flag_zero}, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    tick();
    tick();
    reset = 1'b0;

    // Basic add
    load(3'd1, 8'd4);
    load(3'd2, 8'd8);
    set_ins(OP_ADD, 3'd1, 3'd2, 3'd3, 1'b1, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    chk("add_alu_a", bus.alu_a, 4);
    chk("add_alu_b", bus.alu_b, 8);
    chk("add_alu_op", bus.alu_op, 0);
    chk("add_carry_in", bus.alu_carry_in, 0);
    chk("add_retire_valid", bus.retire_valid, 1);
    chk("add_retire_data", bus.retire_data, 12);
    tick();
    chk("add_retire_drop", bus.retire_valid, 0);
    chk("add_flags", {bus.flag_carry, bus.flag_gt, bus.flag_eq, bus.flag_zero}, 0);
    peek("add_r3", 3'd3, 12);

    // Carry bypass into a back-to-back add
    load(3'd6, 8'd255);
    load(3'd7, 8'd1);
    set_ins(OP_ADD, 3'd6, 3'd7, 3'd3, 1'b1, 1'b0);
    tick();
    chk("cy_first_data", bus.retire_data, 0);
    set_ins(OP_ADD, 3'd1, 3'd2, 3'd5, 1'b1, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    chk("cy_carry_in", bus.alu_carry_in, 1);
    chk("cy_second_data", bus.retire_data, 13);
    chk("cy_flag_carry1", bus.flag_carry, 1);
    chk("cy_flag_zero1", bus.flag_zero, 1);
    tick();
    chk("cy_flag_carry2", bus.flag_carry, 0);
    peek("cy_r5", 3'd5, 13);
    peek("cy_r3", 3'd3, 0);

    // Data bypass: xor reads r3 while r3 is still in execute
    set_ins(OP_ADD, 3'd1, 3'd2, 3'd3, 1'b1, 1'b0);
    tick();
    chk("byp_first_data", bus.retire_data, 12);
    set_ins(OP_XOR, 3'd3, 3'd2, 3'd4, 1'b1, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    chk("byp_alu_a", bus.alu_a, 12);
    chk("byp_retire_data", bus.retire_data, 4);
    tick();
    peek("byp_r4", 3'd4, 4);
    peek("byp_r3", 3'd3, 12);

    // Compare without writeback
    load(3'd1, 8'd8);
    load(3'd2, 8'd4);
    set_ins(OP_CMP, 3'd1, 3'd2, 3'd5, 1'b0, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    chk("cmp_retire_valid", bus.retire_valid, 1);
    tick();
    chk("cmp_gt_eq_zero", {bus.flag_gt, bus.flag_eq, bus.flag_zero}, 3'b101);
    peek("cmp_r5_kept", 3'd5, 13);
    peek("cmp_r1_kept", 3'd1, 8);
    set_ins(OP_CMP, 3'd1, 3'd1, 3'd5, 1'b0, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("cmp_eq_gt", {bus.flag_eq, bus.flag_gt}, 2'b10);

    // Load holds off the offered instruction
    set_ins(OP_ADD, 3'd1, 3'd1, 3'd6, 1'b1, 1'b0);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 3'd7;
    bus.ld_data  = 8'd9;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("ld_in_ready_low", bus.in_ready, 0);
      tick();
      chk("ld_no_accept", bus.retire_valid, 0);
    end
    bus.ld_valid = 1'b0;
    #1;
    chk("ld_in_ready_high", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    chk("ld_accept_valid", bus.retire_valid, 1);
    chk("ld_accept_data", bus.retire_data, 16);
    tick();
    peek("ld_r6", 3'd6, 16);
    peek("ld_r7", 3'd7, 9);

    // Load and writeback hit r3 at the same edge
    set_ins(OP_ADD, 3'd1, 3'd2, 3'd3, 1'b1, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 3'd3;
    bus.ld_data  = 8'd77;
    tick();
    bus.ld_valid = 1'b0;
    peek("ldwb_r3", 3'd3, 77);
    chk("ldwb_flag_gt", bus.flag_gt, 1);

    // Reset while an add to r3 is in execute
    set_ins(OP_ADD, 3'd1, 3'd2, 3'd3, 1'b1, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    chk("rx_pre_valid", bus.retire_valid, 1);
    reset = 1'b1;
    #1;
    chk("rx_retire_valid", bus.retire_valid, 0);
    chk("rx_retire_data", bus.retire_data, 0);
    chk("rx_alu_a", bus.alu_a, 0);
    tick();
    peek("rx_r3", 3'd3, 0);
    peek("rx_r1", 3'd1, 0);
    chk("rx_flags", {bus.flag_carry, bus.flag_gt, bus.flag_eq, bus.flag_zero}, 0);
    reset = 1'b0;
    #1;
    chk("rx_in_ready", bus.in_ready, 1);
    tick();
    chk("rx_idle", bus.retire_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
